// File: rtl/flash_program_sequencer_if.sv
// Bundle of the command, payload-stream and SPI-flash-engine signals around
// flash_program_sequencer.
//   master : the sequencer's view. It receives the command and payload, drives
//            the engine strobes, address and byte stream, and reports status.
//   slave  : the environment's view (command source, payload source, engine).
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len  program command handshake
//   s_tdata/s_tvalid/s_tready             payload byte stream from the network
//   fl_*                                  SPI flash engine control/data/status
//   busy/done/error                       sequencer status
interface flash_program_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_addr;
  logic [16:0] cmd_len;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        fl_write_strobe;
  logic        fl_erase_strobe;
  logic [23:0] fl_start_addr;
  logic [7:0]  fl_tdata;
  logic        fl_tvalid;
  logic        fl_tready;
  logic        fl_finished;
  logic        fl_spi_cs;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len,
    input  s_tdata, s_tvalid,
    input  fl_tready, fl_finished, fl_spi_cs,
    output cmd_ready, s_tready,
    output fl_write_strobe, fl_erase_strobe, fl_start_addr, fl_tdata, fl_tvalid,
    output busy, done, error
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len,
    output s_tdata, s_tvalid,
    output fl_tready, fl_finished, fl_spi_cs,
    input  cmd_ready, s_tready,
    input  fl_write_strobe, fl_erase_strobe, fl_start_addr, fl_tdata, fl_tvalid,
    input  busy, done, error
  );
endinterface

// File: rtl/flash_program_sequencer.sv
// Command-level controller in front of the SPI flash engine. One command
// (address + length) erases every sector the range touches, then programs
// the payload in page-aligned chunks. Each chunk is staged in a page buffer
// first, so the engine sees an unbroken byte stream for a whole page.
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset; drops every strobe immediately
//   bus    flash_program_sequencer_if.master (command, payload, engine, status)
// Parameters:
//   PAGE_BYTES    program chunk / buffer depth (power of two, <= 65536)
//   SECTOR_BYTES  erase granularity (power of two)
//   TIMEOUT_W     watchdog width; a wait state gives up after 2^TIMEOUT_W-1 cycles
module flash_program_sequencer #(
  parameter int PAGE_BYTES   = 256,
  parameter int SECTOR_BYTES = 4096,
  parameter int TIMEOUT_W    = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  flash_program_sequencer_if.master  bus
);

  localparam int PB_W = $clog2(PAGE_BYTES);

  localparam logic [PB_W:0]        PAGE_SIZE = PAGE_BYTES[PB_W:0];
  localparam logic [PB_W:0]        CNT_ONE   = 1;
  localparam logic [24:0]          SEC_STEP  = 25'(SECTOR_BYTES);
  localparam logic [24:0]          SEC_MASK  = ~(25'(SECTOR_BYTES) - 25'd1);
  localparam logic [TIMEOUT_W-1:0] WD_ONE    = 1;
  // Last count before expiry: the state is left on the (2^W-1)-th cycle.
  localparam logic [TIMEOUT_W-1:0] WD_LIMIT  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    IDLE,
    ERASE,
    GAP_E,
    FILL,
    PROG,
    TAIL,
    GAP_P,
    DONE,
    ERR
  } state_t;

  state_t                state;
  logic [23:0]           cur_addr;
  logic [23:0]           sec_addr;
  logic [24:0]           last_sec;
  logic [16:0]           remaining;
  logic [PB_W:0]         fill_cnt;
  logic [PB_W:0]         rd_cnt;
  logic                  gap_cnt;
  logic [TIMEOUT_W-1:0]  wd;

  logic [7:0]            page_buf [PAGE_BYTES];

  logic [PB_W:0]         page_room;
  logic [16:0]           room_ext;
  logic [PB_W:0]         chunk;
  logic [PB_W:0]         fill_nxt;
  logic [PB_W:0]         rd_nxt;
  logic [24:0]           cmd_end;
  logic [24:0]           sec_next;
  logic                  buf_we;

  // Chunk size: stop at the page boundary or at the end of the payload.
  // cur_addr and remaining only move in GAP_P, so this is stable through
  // FILL and PROG.
  always_comb begin
    page_room = PAGE_SIZE - {1'b0, cur_addr[PB_W-1:0]};
    room_ext  = 17'(page_room);
    chunk     = (remaining < room_ext) ? remaining[PB_W:0] : page_room;
    fill_nxt  = fill_cnt + CNT_ONE;
    rd_nxt    = rd_cnt + CNT_ONE;
    // 25-bit sum so a range running past 0xFFFFFF is visible as such.
    cmd_end   = {1'b0, bus.cmd_addr} + {8'd0, bus.cmd_len} - 25'd1;
    sec_next  = {1'b0, sec_addr} + SEC_STEP;
  end

  assign buf_we = (state == FILL) && bus.s_tvalid && bus.s_tready;

  // Page buffer write port (data only, no reset).
  always_ff @(posedge clk) begin
    if (buf_we) page_buf[fill_cnt[PB_W-1:0]] <= bus.s_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      cur_addr            <= '0;
      sec_addr            <= '0;
      last_sec            <= '0;
      remaining           <= '0;
      fill_cnt            <= '0;
      rd_cnt              <= '0;
      gap_cnt             <= 1'b0;
      wd                  <= '0;
      bus.cmd_ready       <= 1'b1;
      bus.s_tready        <= 1'b0;
      bus.fl_write_strobe <= 1'b0;
      bus.fl_erase_strobe <= 1'b0;
      bus.fl_start_addr   <= '0;
      bus.fl_tdata        <= '0;
      bus.fl_tvalid       <= 1'b0;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.error           <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            cur_addr      <= bus.cmd_addr;
            remaining     <= bus.cmd_len;
            sec_addr      <= bus.cmd_addr & SEC_MASK[23:0];
            last_sec      <= cmd_end & SEC_MASK;
            fill_cnt      <= '0;
            rd_cnt        <= '0;
            wd            <= '0;
            bus.error     <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (bus.cmd_len == 17'd0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state               <= ERASE;
              bus.fl_erase_strobe <= 1'b1;
              bus.fl_start_addr   <= bus.cmd_addr & SEC_MASK[23:0];
            end
          end
        end

        ERASE: begin
          if (bus.fl_finished) begin
            state               <= GAP_E;
            bus.fl_erase_strobe <= 1'b0;
            gap_cnt             <= 1'b0;
            wd                  <= '0;
          end else if (wd == WD_LIMIT) begin
            state               <= ERR;
            bus.fl_erase_strobe <= 1'b0;
            bus.error           <= 1'b1;
            wd                  <= '0;
          end else begin
            wd <= bus.fl_tready ? '0 : wd + WD_ONE;
          end
        end

        // Two strobe-low cycles let the engine fall back to idle.
        GAP_E: begin
          if (gap_cnt) begin
            // A sector past 0xFFFFFF is never erased: the 24-bit program
            // address wraps instead.
            if (({1'b0, sec_addr} == last_sec) || sec_next[24]) begin
              state        <= FILL;
              bus.s_tready <= 1'b1;
            end else begin
              state               <= ERASE;
              sec_addr            <= sec_next[23:0];
              bus.fl_erase_strobe <= 1'b1;
              bus.fl_start_addr   <= sec_next[23:0];
              wd                  <= '0;
            end
          end else begin
            gap_cnt <= 1'b1;
          end
        end

        // No watchdog here: the payload source may stall indefinitely.
        FILL: begin
          if (bus.s_tvalid && bus.s_tready) begin
            fill_cnt <= fill_nxt;
            if (fill_nxt == chunk) begin
              state               <= PROG;
              bus.s_tready        <= 1'b0;
              bus.fl_write_strobe <= 1'b1;
              bus.fl_start_addr   <= cur_addr;
              rd_cnt              <= '0;
              wd                  <= '0;
            end
          end
        end

        PROG: begin
          if (bus.fl_tvalid && bus.fl_tready) begin
            rd_cnt <= rd_nxt;
            wd     <= '0;
            if (rd_nxt == chunk) begin
              state         <= TAIL;
              bus.fl_tvalid <= 1'b0;
            end else begin
              bus.fl_tdata <= page_buf[rd_nxt[PB_W-1:0]];
            end
          end else if (wd == WD_LIMIT) begin
            state               <= ERR;
            bus.fl_write_strobe <= 1'b0;
            bus.fl_tvalid       <= 1'b0;
            bus.error           <= 1'b1;
            wd                  <= '0;
          end else begin
            wd <= wd + WD_ONE;
            // First byte is fetched one cycle into PROG: the last FILL write
            // may have landed in the same cycle as the transition.
            if (!bus.fl_tvalid) begin
              bus.fl_tdata  <= page_buf[rd_cnt[PB_W-1:0]];
              bus.fl_tvalid <= 1'b1;
            end
          end
        end

        // Strobe stays up until the engine has shifted out the last byte.
        TAIL: begin
          if (bus.fl_spi_cs) begin
            state               <= GAP_P;
            bus.fl_write_strobe <= 1'b0;
            gap_cnt             <= 1'b0;
            wd                  <= '0;
          end else if (wd == WD_LIMIT) begin
            state               <= ERR;
            bus.fl_write_strobe <= 1'b0;
            bus.error           <= 1'b1;
            wd                  <= '0;
          end else begin
            wd <= bus.fl_tready ? '0 : wd + WD_ONE;
          end
        end

        GAP_P: begin
          if (gap_cnt) begin
            cur_addr  <= cur_addr + 24'(chunk);
            remaining <= remaining - 17'(chunk);
            fill_cnt  <= '0;
            rd_cnt    <= '0;
            if (remaining == 17'(chunk)) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state        <= FILL;
              bus.s_tready <= 1'b1;
            end
          end else begin
            gap_cnt <= 1'b1;
          end
        end

        DONE: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end

        ERR: begin
          state         <= IDLE;
          bus.s_tready  <= 1'b0;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/flash_program_sequencer.md
Name: flash_program_sequencer

Overview:
- Command-level controller placed directly upstream of the SPI flash engine. That engine exposes level-held read/write/erase strobes, a 24-bit start address, a byte-stream input (tdata/tvalid/tready) and a finished flag.
- Takes one program command (flash address + byte length) plus a byte stream from the network receive path.
- Erases every 4 KiB sector touched, then programs the data in page-aligned chunks of at most 256 bytes.
- Stages each chunk in an internal page buffer, so tvalid never drops mid-page and the engine does not end a page early.

Parameters:
- PAGE_BYTES, 256, program chunk and buffer depth; power of two.
- SECTOR_BYTES, 4096, erase granularity; power of two.
- TIMEOUT_W, 24, watchdog counter width; a timeout occurs after 2^TIMEOUT_W-1 cycles in any wait state.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  program command request
- cmd_ready  out  1  high only in IDLE
- cmd_addr  in  24  first flash byte address
- cmd_len  in  17  byte count, 0..65536
- s_tdata  in  8  payload byte
- s_tvalid  in  1  payload valid
- s_tready  out  1  payload accept
- fl_write_strobe  out  1  level strobe to engine, page program
- fl_erase_strobe  out  1  level strobe to engine, sector erase
- fl_start_addr  out  24  address for current erase/program
- fl_tdata  out  8  byte to engine
- fl_tvalid  out  1  byte valid to engine
- fl_tready  in  1  one-cycle pulse: engine consumed the held fl_tdata
- fl_finished  in  1  engine erase-command completion
- fl_spi_cs  in  1  monitor of the engine's chip select
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at successful end
- error  out  1  sticky watchdog flag; cleared on the next accepted command

Behaviour:
- Reset (rst_n low, async): state IDLE. All strobes, fl_tvalid, s_tready, busy, done and error = 0; cmd_ready = 1; fl_start_addr, fl_tdata and all counters = 0.
- Command capture:
  - Accepted when cmd_valid && cmd_ready.
  - cur_addr = cmd_addr; remaining = cmd_len.
  - sec_addr = cmd_addr with low log2(SECTOR_BYTES) bits cleared.
  - last_sec = (cmd_addr+cmd_len-1), same bits cleared, computed in 25 bits.
  - cmd_len == 0: go to DONE directly; no strobes.
- States:
  - IDLE: wait for a command.
  - ERASE: fl_erase_strobe = 1, fl_start_addr = sec_addr. Wait for fl_finished = 1, then go to GAP_E.
  - GAP_E: both strobes low for exactly 2 cycles so the engine returns to idle.
    - If sec_addr == last_sec: go to FILL.
    - Else sec_addr += SECTOR_BYTES and go to ERASE.
  - FILL:
    - chunk = min(remaining, PAGE_BYTES - cur_addr[7:0]).
    - s_tready = 1 while fill_cnt < chunk; each s_tvalid && s_tready writes the page buffer at fill_cnt and increments it.
    - At fill_cnt == chunk: s_tready = 0, go to PROG.
  - PROG:
    - fl_write_strobe = 1, fl_start_addr = cur_addr.
    - fl_tvalid = 1 with fl_tdata = buf[rd_cnt] while rd_cnt < chunk.
    - fl_tdata is held stable until an fl_tready pulse, then rd_cnt increments and the next byte is presented in the following cycle.
    - After the last pulse, fl_tvalid = 0 and go to TAIL.
  - TAIL: wait for fl_spi_cs = 1 (engine has shifted the last byte and released CS), then go to GAP_P.
  - GAP_P:
    - Strobes low for 2 cycles.
    - cur_addr += chunk; remaining -= chunk; fill_cnt = rd_cnt = 0.
    - remaining == 0: go to DONE; else go to FILL.
  - DONE: done = 1 for one cycle, then IDLE.
  - ERR: entered from ERASE, PROG or TAIL on watchdog expiry. All strobes drop and error = 1. Drain/ignore: s_tready = 0. Go to IDLE.
- Watchdog: cleared on every state change and on every fl_tready pulse; increments otherwise in ERASE, PROG and TAIL.
- Erase and program never assert simultaneously; the engine's own status polling covers program/erase busy time.
- Address wrap: a program crossing 0xFFFFFF wraps cur_addr modulo 2^24. last_sec is computed on the 25-bit sum; a sector past the top is not erased.
- Page buffer: simple dual-port array, PAGE_BYTES x 8. Read address is rd_cnt, registered; fl_tdata comes from a register, never combinationally from the array.
- Input stalls: s_tvalid gaps during FILL are tolerated indefinitely (no watchdog in FILL).
- Reset mid-operation: strobes drop asynchronously, which forces the engine to idle; no partial state survives.

Test Plan:
- cmd_addr=0x010000, len=256, incrementing data -> one erase at 0x010000, one program of 256 bytes at 0x010000, done pulse; flash model contents match.
- cmd_addr=0x0100F0, len=32 -> programs 16 bytes at 0x0100F0 then 16 bytes at 0x010100; fl_tvalid never low mid-chunk.
- cmd_addr=0x010FFF, len=2 -> erases 0x010000 and 0x011000 in order, with a 2-cycle strobe gap between them.
- s_tvalid toggled randomly at 30% duty during FILL -> byte order preserved; fl_tvalid continuous in PROG.
- Engine model never pulses fl_finished -> error=1 after 2^24-1 cycles, strobes low, cmd_ready=1.
- rst_n pulsed low during PROG -> outputs at reset values immediately; the next command runs normally; len=0 -> done pulse with no strobes.
